// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- single-cycle registered arithmetic/logic unit.
//
// Every rising clk edge samples in1/in2/alu_opcode and registers the result
// together with a zero flag, so each result appears exactly one cycle after its
// operands are presented. There is no enable or handshake.
//
// Opcodes: 000 PASS, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR,
//          110 SHL (by in2, zero fill), 111 SHR (by in2, zero fill).
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (out = 0, zero_flag = 1)
//   in1         operand A, unsigned, SIZE bits
//   in2         operand B / shift amount, unsigned, SIZE bits
//   alu_opcode  3-bit operation select
//   out         registered result, SIZE bits
//   zero_flag   registered, 1 when out == 0
//   carry_flag  registered carry/borrow (only when ALU_CARRY_EN is defined)
//
// Build option: define ALU_CARRY_EN to add carry_flag and its logic.
// -----------------------------------------------------------------------------
module alu #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  input  logic [2:0]      alu_opcode,
  output logic [SIZE-1:0] out,
  output logic            zero_flag
`ifdef ALU_CARRY_EN
  ,
  output logic            carry_flag
`endif
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  logic [SIZE-1:0] and_vec;
  logic [SIZE-1:0] or_vec;
  logic [SIZE-1:0] xor_vec;
  logic [SIZE-1:0] sum_res;
  logic [SIZE-1:0] diff_res;
  logic [SIZE-1:0] shl_res;
  logic [SIZE-1:0] shr_res;
  logic [SIZE-1:0] result_next;
  logic            zero_next;
  logic [SIZE-1:0] out_reg;
  logic            zero_reg;

  // Bitwise operations, one slice per bit.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bitwise
      assign and_vec[gi] = in1[gi] & in2[gi];
      assign or_vec[gi]  = in1[gi] | in2[gi];
      assign xor_vec[gi] = in1[gi] ^ in2[gi];
    end
  endgenerate

  // A logical shift by the full SIZE-bit in2 already yields 0 for any
  // amount >= SIZE, so no separate range check is needed.
  assign shr_res = in1 >> in2;

`ifdef ALU_CARRY_EN
  // One-bit-wider datapaths: bit SIZE carries the carry, borrow, or the last
  // bit pushed out past the MSB. For the shift, amounts above SIZE push the
  // original bits beyond bit SIZE, leaving it 0; shift 0 leaves it 0 too.
  logic [SIZE:0] sum_ext;
  logic [SIZE:0] diff_ext;
  logic [SIZE:0] shl_ext;
  logic          carry_next;
  logic          carry_reg;

  assign sum_ext  = {1'b0, in1} + {1'b0, in2};
  assign diff_ext = {1'b0, in1} - {1'b0, in2};
  assign shl_ext  = {1'b0, in1} << in2;
  assign sum_res  = sum_ext[SIZE-1:0];
  assign diff_res = diff_ext[SIZE-1:0];
  assign shl_res  = shl_ext[SIZE-1:0];

  always_comb begin
    carry_next = 1'b0;
    case (alu_opcode)
      OP_ADD:  carry_next = sum_ext[SIZE];
      OP_SUB:  carry_next = diff_ext[SIZE];
      OP_SHL:  carry_next = shl_ext[SIZE];
      default: carry_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
    end else begin
      carry_reg <= carry_next;
    end
  end

  assign carry_flag = carry_reg;
`else
  assign sum_res  = in1 + in2;
  assign diff_res = in1 - in2;
  assign shl_res  = in1 << in2;
`endif

  always_comb begin
    result_next = in1;
    case (alu_opcode)
      OP_PASS: result_next = in1;
      OP_ADD:  result_next = sum_res;
      OP_SUB:  result_next = diff_res;
      OP_AND:  result_next = and_vec;
      OP_OR:   result_next = or_vec;
      OP_XOR:  result_next = xor_vec;
      OP_SHL:  result_next = shl_res;
      OP_SHR:  result_next = shr_res;
      default: result_next = in1;
    endcase
  end

  // Derived from the same combinational result that is loaded into out_reg,
  // so the flag can never disagree with the registered value.
  assign zero_next = (result_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      zero_reg <= 1'b1;
    end else begin
      out_reg  <= result_next;
      zero_reg <= zero_next;
    end
  end

  assign out       = out_reg;
  assign zero_flag = zero_reg;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (SIZE = 4).
// Directed vectors, an 8-opcode back-to-back sweep, asynchronous reset checks
// and randomized operations, all compared against an arithmetic model.
// Define ALU_CARRY_EN for both bench and design to also check carry_flag.
// -----------------------------------------------------------------------------
module tb_alu;

  localparam int SIZE = 4;
  localparam int MOD  = 1 << SIZE;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] in1;
  logic [SIZE-1:0] in2;
  logic [2:0]      alu_opcode;
  logic [SIZE-1:0] out;
  logic            zero_flag;
`ifdef ALU_CARRY_EN
  logic            carry_flag;
`endif

  int checks   = 0;
  int failures = 0;
  int prev_exp = 0;

  alu #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1        (in1),
    .in2        (in2),
    .alu_opcode (alu_opcode),
    .out        (out),
    .zero_flag  (zero_flag)
`ifdef ALU_CARRY_EN
    ,
    .carry_flag (carry_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic int model_out(input int op, input int a, input int b);
    case (op)
      0: return a;
      1: return (a + b) % MOD;
      2: return (a - b + MOD) % MOD;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (b >= SIZE) ? 0 : (a * (1 << b)) % MOD;
      default: return (b >= SIZE) ? 0 : a / (1 << b);
    endcase
  endfunction

  function automatic int model_carry(input int op, input int a, input int b);
    case (op)
      1: return (a + b >= MOD) ? 1 : 0;
      2: return (a < b) ? 1 : 0;
      6: return (b == 0 || b > SIZE) ? 0 : ((a * (1 << b)) / MOD) % 2;
      default: return 0;
    endcase
  endfunction

  // Called one time unit after a rising edge. Presents operands, confirms the
  // previous result is still held before the edge, then checks the new result
  // one time unit after the following edge.
  task automatic do_op(input string tag, input int op, input int a, input int b);
    int exp_out;
    in1        = SIZE'(a);
    in2        = SIZE'(b);
    alu_opcode = 3'(op);
    exp_out    = model_out(op, a, b);
    #1;
    check({tag, "_hold"}, 32'(out), 32'(prev_exp));
    @(posedge clk);
    #1;
    $display("op=%0d in1=%0d in2=%0d out=%0d zero=%0b (%s)", op, a, b, out,
             zero_flag, tag);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_zero"}, 32'(zero_flag), (exp_out == 0) ? 32'd1 : 32'd0);
`ifdef ALU_CARRY_EN
    check({tag, "_carry"}, 32'(carry_flag), 32'(model_carry(op, a, b)));
`endif
    prev_exp = exp_out;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b1;
    in1        = '0;
    in2        = '0;
    alu_opcode = '0;
    #1;
    rst_n = 1'b0;
    #1;  // t=2, before any clock edge
    check("rst_async_out", 32'(out), 32'd0);
    check("rst_async_zero", 32'(zero_flag), 32'd1);
`ifdef ALU_CARRY_EN
    check("rst_async_carry", 32'(carry_flag), 32'd0);
`endif
    in1 = 4'd5; alu_opcode = 3'd0;
    @(posedge clk);
    #1;
    check("rst_held_out", 32'(out), 32'd0);
    check("rst_held_zero", 32'(zero_flag), 32'd1);
    rst_n    = 1'b1;
    prev_exp = 0;

    // Directed vectors
    do_op("sub_eq",   2, 6, 6);
    do_op("add",      1, 3, 6);
    do_op("add_wrap", 1, 15, 1);
    do_op("sub",      2, 15, 6);
    do_op("sub_brw",  2, 1, 2);
    do_op("and",      3, 15, 6);
    do_op("or",       4, 9, 6);
    do_op("xor",      5, 11, 6);
    do_op("pass",     0, 8, 0);
    do_op("shl3",     6, 13, 3);
    do_op("shr2",     7, 13, 2);
    do_op("shl4",     6, 13, 4);
    do_op("shl5",     6, 13, 5);
    do_op("shr15",    7, 15, 15);
    do_op("shl0",     6, 9, 0);

    // Back-to-back: one opcode per cycle, results expected with no gaps.
    for (int op = 0; op < 8; op++) begin
      do_op("b2b", op, int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, MOD - 1)));
    end

    // Reset asserted mid-cycle while an ADD is pending.
    in1 = 4'd3; in2 = 4'd6; alu_opcode = 3'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_zero", 32'(zero_flag), 32'd1);
    @(posedge clk);
    #1;
    check("mid_rst_edge_out", 32'(out), 32'd0);
    rst_n    = 1'b1;
    prev_exp = 0;
    do_op("post_rst", 0, 5, 0);

    // Randomized operations
    for (int i = 0; i < 300; i++) begin
      do_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, MOD - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter SIZE, default 4, operand and result width in bits; the block SHALL support any SIZE >= 2.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in1  input  SIZE  operand A, unsigned.
REQ-005 in2  input  SIZE  operand B, unsigned; also the shift amount for shift opcodes.
REQ-006 alu_opcode  input  3  operation select.
REQ-007 out  output  SIZE  registered result.
REQ-008 zero_flag  output  1  registered; 1 when the registered out equals 0.
REQ-009 carry_flag  output  1  registered carry/borrow; present only when ALU_CARRY_EN is defined (REQ-024).

Function
REQ-010 Opcode 000 (PASS) SHALL produce out = in1.
REQ-011 Opcode 001 (ADD) SHALL produce out = (in1 + in2) mod 2^SIZE; carry-out is discarded from out.
REQ-012 Opcode 010 (SUB) SHALL produce out = (in1 - in2) mod 2^SIZE, two's-complement wrap-around.
REQ-013 Opcode 011 (AND) SHALL produce out = bitwise in1 AND in2.
REQ-014 Opcode 100 (OR) SHALL produce out = bitwise in1 OR in2.
REQ-015 Opcode 101 (XOR) SHALL produce out = bitwise in1 XOR in2.
REQ-016 Opcode 110 (SHL) SHALL produce out = in1 logically shifted left by in2 positions, zero fill; in2 >= SIZE SHALL give out = 0.
REQ-017 Opcode 111 (SHR) SHALL produce out = in1 logically shifted right by in2 positions, zero fill; in2 >= SIZE SHALL give out = 0.
REQ-018 Inputs SHALL be sampled on every rising clk edge; out and zero_flag SHALL update on that edge, giving a latency of exactly 1 cycle and a throughput of 1 operation per cycle.
REQ-019 zero_flag SHALL be computed from the same-cycle result, so it is always consistent with out; there is no enable or handshake.
REQ-020 No X-propagation SHALL originate in the block; all 8 opcodes are defined and no opcode is illegal.

Reset
REQ-021 While rst_n = 0, out SHALL be 0 and zero_flag SHALL be 1, asynchronously and regardless of clk.
REQ-022 carry_flag, when present, SHALL be 0 during reset.
REQ-023 After rst_n deasserts, the first rising clk edge SHALL load the result of the current inputs; an assertion mid-operation SHALL discard the pending result.

Configuration
REQ-024 Macro ALU_CARRY_EN: when defined, port carry_flag SHALL exist and be registered with out:
- ADD: carry-out of the SIZE-bit sum.
- SUB: borrow, 1 when in1 < in2.
- SHL: last bit shifted out of the MSB, or 0 for shift 0 or shift >= SIZE+1.
- All other opcodes: 0.
When the macro is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (SIZE = 4; result checked one edge after stimulus)
REQ-025 Reset and zero cases:
- rst_n = 0 -> out = 0000, zero_flag = 1 without a clock edge.
- SUB in1 = 0110, in2 = 0110 -> out = 0000, zero_flag = 1.
REQ-026 Arithmetic:
- ADD 0011 + 0110 -> out = 1001, zero_flag = 0.
- ADD 1111 + 0001 -> out = 0000, zero_flag = 1, carry_flag = 1 when enabled.
- SUB 1111 - 0110 -> out = 1001.
- SUB 0001 - 0010 -> out = 1111, carry_flag = 1 when enabled.
REQ-027 Logic:
- AND 1111, 0110 -> out = 0110.
- OR 1001, 0110 -> out = 1111.
- XOR 1011, 0110 -> out = 1101.
- PASS in1 = 1000 -> out = 1000.
REQ-028 Shifts:
- SHL 1101 by 0011 -> out = 1000.
- SHR 1101 by 0010 -> out = 0011.
- SHL 1101 by 0100 -> out = 0000, zero_flag = 1.
REQ-029 Back-to-back: change the opcode every cycle through all 8 opcodes -> each result appears exactly 1 cycle later with no gaps.
REQ-030 Reset mid-stream: assert rst_n between two edges while an ADD is presented -> out = 0000 immediately; the pending result is never output.
